// File: rtl/dla_platform_msi_request_pkg.sv
// Shared types and helpers for the platform MSI request block.
package dla_platform_msi_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HOLDOFF = 2'd2
    } msi_state_t;

    // Counter width able to hold n-1, never narrower than one bit.
    function automatic int msi_cnt_bits(input int n);
        int b;
        b = $clog2(n);
        return (b < 1) ? 1 : b;
    endfunction

endpackage

// File: rtl/dla_platform_msi_request_if.sv
// MSI request channel toward the PCIe hard IP. o_msi_req rises with a valid vector and stays
// stable until the IP returns a one-cycle i_msi_ack (or the requester abandons it on timeout).
interface dla_platform_msi_request_if #(
    parameter int VECTOR_WIDTH = 5
) ();
    logic                    o_msi_req;
    logic [VECTOR_WIDTH-1:0] o_msi_vector;
    logic                    i_msi_ack;

    modport master (output o_msi_req, output o_msi_vector, input i_msi_ack);
    modport slave  (input o_msi_req, input o_msi_vector, output i_msi_ack);
endinterface

// File: rtl/dla_platform_msi_request_down_timer.sv
// Loadable down counter with zero flag; it stops at zero instead of wrapping.
module dla_platform_msi_down_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             i_sclr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);
    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (i_sclr) begin
            cnt_q <= '0;
        end else if (i_load) begin
            cnt_q <= i_load_val;
        end else if (i_dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign o_zero = (cnt_q == '0);
endmodule

// File: rtl/dla_platform_msi_request.sv
// Turns rising edges of the retried interrupt level into single MSI req/ack transactions.
// Optional statistics counters are built when DLA_PLATFORM_MSI_STATS_EN is defined.
module dla_platform_msi_request
    import dla_platform_msi_pkg::*;
#(
    parameter int MSI_VECTOR     = 0,
    parameter int VECTOR_WIDTH   = 5,
    parameter int HOLDOFF_CYCLES = 256,
    parameter int ACK_TIMEOUT    = 4096,
    parameter int STATS_WIDTH    = 32
) (
    input  logic                   clk,
    input  logic                   i_sclr,
    input  logic                   i_interrupt_level,
    input  logic                   i_msi_enable,
    dla_platform_msi_request_if.master msi,
    output logic                   o_ack_timeout,
    output logic                   o_error,
`ifdef DLA_PLATFORM_MSI_STATS_EN
    output logic [STATS_WIDTH-1:0] o_msi_sent_count,
    output logic [STATS_WIDTH-1:0] o_coalesced_count,
`endif
    output msi_state_t             o_dbg_state
);
    localparam int TO_W = msi_cnt_bits(ACK_TIMEOUT);
    localparam int HO_W = msi_cnt_bits(HOLDOFF_CYCLES);
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [HO_W-1:0] HO_LOAD = HO_W'(HOLDOFF_CYCLES - 1);
    localparam logic [VECTOR_WIDTH-1:0] VEC = VECTOR_WIDTH'(MSI_VECTOR);

    generate
        if (HOLDOFF_CYCLES < 1) begin : g_bad_holdoff
            $error("HOLDOFF_CYCLES must be >= 1");
        end
        if (ACK_TIMEOUT < 2) begin : g_bad_timeout
            $error("ACK_TIMEOUT must be >= 2");
        end
        if (STATS_WIDTH < 1) begin : g_bad_stats
            $error("STATS_WIDTH must be >= 1");
        end
    endgenerate

    msi_state_t              state_q;
    logic                    lvl_q;
    logic                    lvl_prev_q;
    logic                    pending_q;
    logic                    req_q;
    logic [VECTOR_WIDTH-1:0] vec_q;
    logic                    timeout_q;
    logic                    error_q;

    logic rise;
    logic start;
    logic ack_take;
    logic to_zero;
    logic to_expire;
    logic ho_zero;

    assign rise      = lvl_q & ~lvl_prev_q;
    assign start     = (state_q == IDLE) & (rise | pending_q) & i_msi_enable;
    assign ack_take  = (state_q == REQ) & msi.i_msi_ack;
    // Ack beats an expiring timer in the same cycle.
    assign to_expire = (state_q == REQ) & ~msi.i_msi_ack & to_zero;

    dla_platform_msi_down_timer #(.WIDTH(TO_W)) u_ack_timer (
        .clk        (clk),
        .i_sclr     (i_sclr),
        .i_load     (start),
        .i_load_val (TO_LOAD),
        .i_dec      ((state_q == REQ) & ~msi.i_msi_ack),
        .o_zero     (to_zero)
    );

    dla_platform_msi_down_timer #(.WIDTH(HO_W)) u_holdoff_timer (
        .clk        (clk),
        .i_sclr     (i_sclr),
        .i_load     (ack_take | to_expire),
        .i_load_val (HO_LOAD),
        .i_dec      (state_q == HOLDOFF),
        .o_zero     (ho_zero)
    );

    always_ff @(posedge clk) begin
        if (i_sclr) begin
            state_q    <= IDLE;
            lvl_q      <= 1'b0;
            lvl_prev_q <= 1'b0;
            pending_q  <= 1'b0;
            req_q      <= 1'b0;
            vec_q      <= '0;
            timeout_q  <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            lvl_q      <= i_interrupt_level;
            lvl_prev_q <= lvl_q;
            timeout_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= REQ;
                        req_q     <= 1'b1;
                        vec_q     <= VEC;
                        pending_q <= 1'b0;
                    end else if (rise) begin
                        pending_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (rise) pending_q <= 1'b1;
                    if (ack_take || to_expire) begin
                        state_q <= HOLDOFF;
                        req_q   <= 1'b0;
                        vec_q   <= '0;
                    end
                    // Abandoned attempt: the retry stage upstream will raise the level again.
                    if (to_expire) begin
                        timeout_q <= 1'b1;
                        error_q   <= 1'b1;
                    end
                end
                HOLDOFF: begin
                    if (rise) pending_q <= 1'b1;
                    if (ho_zero) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef DLA_PLATFORM_MSI_STATS_EN
    logic [STATS_WIDTH-1:0] sent_q;
    logic [STATS_WIDTH-1:0] coal_q;
    logic                   coal_ev;

    // A rise is folded into another request whenever one is already owed or in flight.
    assign coal_ev = rise & (pending_q | (state_q != IDLE));

    always_ff @(posedge clk) begin
        if (i_sclr) begin
            sent_q <= '0;
            coal_q <= '0;
        end else begin
            if (ack_take && (sent_q != '1)) sent_q <= sent_q + STATS_WIDTH'(1);
            if (coal_ev && (coal_q != '1)) coal_q <= coal_q + STATS_WIDTH'(1);
        end
    end

    assign o_msi_sent_count  = sent_q;
    assign o_coalesced_count = coal_q;
`endif

    assign msi.o_msi_req    = req_q;
    assign msi.o_msi_vector = vec_q;
    assign o_ack_timeout    = timeout_q;
    assign o_error          = error_q;
    assign o_dbg_state      = state_q;
endmodule

// File: tb/tb_dla_platform_msi_request.sv
// Randomized and directed checks of dla_platform_msi_request against a cycle-count reference model.
module tb_dla_platform_msi_request;
    import dla_platform_msi_pkg::*;

    localparam int MSI_VEC = 5;
    localparam int VW      = 5;
    localparam int HOLD    = 40;
    localparam int TMO     = 16;
    localparam int SW      = 32;
    localparam longint STAT_MAX = (64'd1 << SW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       sclr;
    logic       level;
    logic       en;
    logic       to_pulse;
    logic       err;
    msi_state_t dbg_state;
`ifdef DLA_PLATFORM_MSI_STATS_EN
    logic [SW-1:0] sent_cnt;
    logic [SW-1:0] coal_cnt;
`endif

    dla_platform_msi_request_if #(.VECTOR_WIDTH(VW)) msi_if ();

    dla_platform_msi_request #(
        .MSI_VECTOR     (MSI_VEC),
        .VECTOR_WIDTH   (VW),
        .HOLDOFF_CYCLES (HOLD),
        .ACK_TIMEOUT    (TMO),
        .STATS_WIDTH    (SW)
    ) dut (
        .clk               (clk),
        .i_sclr            (sclr),
        .i_interrupt_level (level),
        .i_msi_enable      (en),
        .msi               (msi_if),
        .o_ack_timeout     (to_pulse),
        .o_error           (err),
`ifdef DLA_PLATFORM_MSI_STATS_EN
        .o_msi_sent_count  (sent_cnt),
        .o_coalesced_count (coal_cnt),
`endif
        .o_dbg_state       (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: request age, cycles since the last request ended, owed request flag.
    bit     m_req = 0;
    int     m_age = 0;
    int     m_gap = HOLD;
    bit     m_pending = 0;
    bit     m_lq = 0;
    bit     m_lp = 0;
    bit     m_tpulse = 0;
    bit     m_err = 0;
    longint m_sent = 0;
    longint m_coal = 0;
    logic [VW-1:0] exp_q[$];

    task automatic count_coalesce();
        if (m_coal < STAT_MAX) m_coal++;
        m_pending = 1;
    endtask

    task automatic model_step(input bit lvl, input bit en_v, input bit ack_v, input bit rst_v);
        bit rise;
        if (rst_v) begin
            m_req = 0; m_age = 0; m_gap = HOLD; m_pending = 0;
            m_lq = 0; m_lp = 0; m_tpulse = 0; m_err = 0;
            m_sent = 0; m_coal = 0;
            exp_q.delete();
            return;
        end
        rise = m_lq & ~m_lp;
        m_tpulse = 0;
        if (m_req) begin
            if (rise) count_coalesce();
            if (ack_v) begin
                m_req = 0; m_gap = 0;
                if (m_sent < STAT_MAX) m_sent++;
            end else if (m_age == TMO) begin
                m_req = 0; m_gap = 0; m_tpulse = 1; m_err = 1;
            end else begin
                m_age++;
            end
        end else if (m_gap < HOLD) begin
            m_gap++;
            if (rise) count_coalesce();
        end else if ((rise || m_pending) && en_v) begin
            if (rise && m_pending && m_coal < STAT_MAX) m_coal++;
            m_req = 1; m_age = 1; m_pending = 0;
            exp_q.push_back(VW'(MSI_VEC));
        end else if (rise) begin
            if (m_pending && m_coal < STAT_MAX) m_coal++;
            m_pending = 1;
        end
        m_lp = m_lq;
        m_lq = lvl;
    endtask

    int   obs_starts = 0;
    int   obs_hi = 0;
    int   obs_to = 0;
    logic prev_req = 1'b0;

    // Drive one cycle of inputs, advance the model, then compare after the edge.
    task automatic step(input bit lvl, input bit en_v, input bit ack_v, input bit rst_v);
        msi_state_t exp_state;
        logic [VW-1:0] v;
        level = lvl; en = en_v; msi_if.i_msi_ack = ack_v; sclr = rst_v;
        model_step(lvl, en_v, ack_v, rst_v);
        @(posedge clk);
        @(negedge clk);
        exp_state = m_req ? REQ : ((m_gap < HOLD) ? HOLDOFF : IDLE);
        check_eq("req", msi_if.o_msi_req, m_req);
        check_eq("vector", msi_if.o_msi_vector, m_req ? MSI_VEC : 0);
        check_eq("ack_timeout", to_pulse, m_tpulse);
        check_eq("error", err, m_err);
        check_eq("state", dbg_state, exp_state);
`ifdef DLA_PLATFORM_MSI_STATS_EN
        check_eq("sent_count", sent_cnt, m_sent);
        check_eq("coalesced_count", coal_cnt, m_coal);
`endif
        if (msi_if.o_msi_req === 1'b1 && prev_req !== 1'b1) begin
            obs_starts++;
            check_eq("req_start_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                v = exp_q.pop_front();
                check_eq("req_start_vector", msi_if.o_msi_vector, v);
            end
        end
        if (msi_if.o_msi_req === 1'b1) obs_hi++;
        if (to_pulse === 1'b1) obs_to++;
        prev_req = msi_if.o_msi_req;
    endtask

    task automatic clear_obs();
        obs_starts = 0; obs_hi = 0; obs_to = 0;
    endtask

    initial begin
        bit r_lvl;
        bit r_en;
        sclr = 1'b1; level = 1'b0; en = 1'b1; msi_if.i_msi_ack = 1'b0;

        repeat (3) step(0, 1, 0, 1);
        check_eq("reset_req", msi_if.o_msi_req, 0);
        check_eq("reset_error", err, 0);

        // Single edge, acked on the third request cycle.
        repeat (10) step(0, 1, 0, 0);
        clear_obs();
        for (int i = 0; i < HOLD + 20; i++) step(1, 1, m_req && m_age == 3, 0);
        check_eq("single_req_count", obs_starts, 1);
        check_eq("single_req_cycles", obs_hi, 3);

        // Three further rises during the transaction collapse into one request.
        repeat (4) step(0, 1, 0, 0);
        clear_obs();
        for (int i = 0; i < 2 * HOLD + 60; i++)
            step(!(i >= 4 && i < 16 && ((i / 2) % 2 == 0)), 1, m_req && m_age == 12, 0);
        check_eq("coalesce_req_count", obs_starts, 2);

        // Ack timeout: no ack at all.
        repeat (5) step(0, 1, 0, 0);
        clear_obs();
        for (int i = 0; i < TMO + HOLD + 10; i++) step(1, 1, 0, 0);
        check_eq("timeout_req_cycles", obs_hi, TMO);
        check_eq("timeout_pulses", obs_to, 1);
        repeat (5) step(0, 1, 0, 0);
        check_eq("error_sticky", err, 1);

        // Enable gating: edge while disabled is remembered until enable rises.
        repeat (2) step(0, 0, 0, 1);
        clear_obs();
        for (int i = 0; i < 35; i++) step(1, 0, 0, 0);
        check_eq("gated_no_req", obs_starts, 0);
        step(1, 1, 0, 0);
        check_eq("enable_latency_req", msi_if.o_msi_req, 1);
        for (int i = 0; i < HOLD + 5; i++) step(1, 1, m_req && m_age == 2, 0);

        // Ack arriving on the final timeout cycle wins.
        repeat (5) step(0, 1, 0, 0);
        clear_obs();
        for (int i = 0; i < TMO + HOLD + 5; i++) step(1, 1, m_req && m_age == TMO, 0);
        check_eq("ack_vs_timeout_pulses", obs_to, 0);
        check_eq("ack_vs_timeout_error", err, 0);
        check_eq("ack_vs_timeout_cycles", obs_hi, TMO);

        // Reset in the middle of a request with the level held high.
        repeat (3) step(0, 1, 0, 0);
        repeat (4) step(1, 1, 0, 0);
        check_eq("mid_req_before_reset", msi_if.o_msi_req, 1);
        step(1, 1, 0, 1);
        check_eq("mid_req_reset_req", msi_if.o_msi_req, 0);
        step(1, 1, 0, 0);
        check_eq("post_reset_edge1_req", msi_if.o_msi_req, 0);
        step(1, 1, 0, 0);
        check_eq("post_reset_edge2_req", msi_if.o_msi_req, 1);
        for (int i = 0; i < HOLD + 20; i++) step(1, 1, m_req && m_age == 4, 0);

        // Randomized traffic.
        r_lvl = 0;
        r_en = 1;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 7) == 0) r_lvl = ~r_lvl;
            if ($urandom_range(0, 49) == 0) r_en = ~r_en;
            step(r_lvl, r_en,
                 m_req ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 19) == 0),
                 $urandom_range(0, 1999) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
